// File: rtl/store_monitor_if.sv
// Bus between a CPU data-memory write port / log reader and the store monitor.
// The master side drives stores and log pops; the slave side (the monitor)
// returns log contents and the run verdict.
interface store_monitor_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic        log_rd;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic [15:0] store_count;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        done;
    logic [31:0] fail_addr;

    modport master (
        output memwrite, aluout, writedata, log_rd,
        input  log_valid, log_addr, log_data, log_overflow, store_count,
               pass, fail, timeout, done, fail_addr
    );

    modport slave (
        input  memwrite, aluout, writedata, log_rd,
        output log_valid, log_addr, log_data, log_overflow, store_count,
               pass, fail, timeout, done, fail_addr
    );
endinterface

// File: rtl/store_monitor.sv
// Store monitor: watches CPU stores, decides pass/fail/timeout for a test run
// and records every store seen during the run in a small FIFO log.
module store_monitor #(
    parameter logic [31:0] TARGET_ADDR = 32'h0000_0010,
    parameter logic [31:0] TARGET_DATA = 32'hFFFF_FFFA,
    parameter logic [31:0] WIN_LO      = 32'h0000_0014,
    parameter logic [31:0] WIN_HI      = 32'h0000_0028,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned LOG_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    store_monitor_if.slave mon_if
);

    localparam int unsigned PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
    localparam logic [CNT_W-1:0] OCC_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] OCC_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] OCC_FULL     = CNT_W'(LOG_DEPTH);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        TOUT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_TARGET  = 2'd0,
        CLS_LEGAL   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } class_t;

    // Target wins over the window; the target address with wrong data is
    // illegal because it lies below the window.
    function automatic class_t classify(input logic [31:0] addr, input logic [31:0] data);
        class_t cls;
        if ((addr == TARGET_ADDR) && (data == TARGET_DATA)) begin
            cls = CLS_TARGET;
        end else if ((addr >= WIN_LO) && (addr <= WIN_HI) && (addr[1:0] == 2'b00)) begin
            cls = CLS_LEGAL;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

    // FSM and run bookkeeping
    state_t      state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic [31:0] fail_addr_q, fail_addr_d;
    logic        pass_q, fail_q, tout_q, done_q;

    // Store log
    logic [31:0]      log_addr_mem_q [LOG_DEPTH];
    logic [31:0]      log_data_mem_q [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;

    class_t store_cls_s;
    logic   push_s;
    logic   pop_s;
    logic   full_s;
    logic   wr_en_s;
    logic   drop_s;

    // Next-state logic: classify stores in RUN, apply the cycle limit, hold terminal states.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        fail_addr_d = fail_addr_q;
        push_s      = 1'b0;
        store_cls_s = classify(mon_if.aluout, mon_if.writedata);
        case (state_q)
            RUN: begin
                push_s = mon_if.memwrite;
                cyc_d  = cyc_q + 32'd1;
                if (mon_if.memwrite && (store_cls_s == CLS_TARGET)) begin
                    state_d = PASS;
                end else if (mon_if.memwrite && (store_cls_s == CLS_ILLEGAL)) begin
                    state_d     = FAIL;
                    fail_addr_d = mon_if.aluout;
                end else if (cyc_q == TIMEOUT_LAST) begin
                    state_d = TOUT;
                end else begin
                    state_d = RUN;
                end
            end
            PASS, FAIL, TOUT: begin
                state_d = state_q;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Saturating count of stores accepted during the run.
    always_comb begin
        store_cnt_d = store_cnt_q;
        if (push_s && (store_cnt_q != 16'hFFFF)) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end else begin
            store_cnt_d = store_cnt_q;
        end
    end

    // Log control: a push into a full log only succeeds when a pop frees the slot that same cycle.
    always_comb begin
        pop_s    = mon_if.log_rd && (occ_q != OCC_ZERO);
        full_s   = (occ_q == OCC_FULL);
        wr_en_s  = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ovf_d    = ovf_q | drop_s;
        case ({wr_en_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // State, counters and verdict flags; verdicts are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cyc_q       <= 32'd0;
            store_cnt_q <= 16'd0;
            fail_addr_q <= 32'd0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tout_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            store_cnt_q <= store_cnt_d;
            fail_addr_q <= fail_addr_d;
            pass_q      <= (state_d == PASS);
            fail_q      <= (state_d == FAIL);
            tout_q      <= (state_d == TOUT);
            done_q      <= (state_d != RUN);
        end
    end

    // Log pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            occ_q    <= OCC_ZERO;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    // Log storage; contents need no reset since empty entries are never shown.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            log_addr_mem_q[wr_ptr_q] <= mon_if.aluout;
            log_data_mem_q[wr_ptr_q] <= mon_if.writedata;
        end
    end

    assign mon_if.log_valid    = (occ_q != OCC_ZERO);
    assign mon_if.log_addr     = (occ_q != OCC_ZERO) ? log_addr_mem_q[rd_ptr_q] : 32'd0;
    assign mon_if.log_data     = (occ_q != OCC_ZERO) ? log_data_mem_q[rd_ptr_q] : 32'd0;
    assign mon_if.log_overflow = ovf_q;
    assign mon_if.store_count  = store_cnt_q;
    assign mon_if.pass         = pass_q;
    assign mon_if.fail         = fail_q;
    assign mon_if.timeout      = tout_q;
    assign mon_if.done         = done_q;
    assign mon_if.fail_addr    = fail_addr_q;

endmodule
